// File: rtl/dmem_if.sv
// Load/store port between the MIPS datapath and its data-memory responder.
interface dmem_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output a, output wd, input rd);
  modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle MIPS core: word RAM plus an MMIO window
// holding an LED register, an interval timer with sticky match flag, and a cycle counter.
module dmem_mmio #(
  parameter int          DEPTH     = 64,
  parameter logic [15:0] MMIO_BASE = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [7:0] led,
  output logic       irq
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] OFF_LED    = 6'd0;
  localparam logic [5:0] OFF_CTRL   = 6'd1;
  localparam logic [5:0] OFF_COUNT  = 6'd2;
  localparam logic [5:0] OFF_CMP    = 6'd3;
  localparam logic [5:0] OFF_STATUS = 6'd4;
  localparam logic [5:0] OFF_CYCLE  = 6'd5;

  logic [31:0] mem [DEPTH];

  logic [7:0]  led_q,   led_d;
  logic [1:0]  ctrl_q,  ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q,   cmp_d;
  logic        flag_q,  flag_d;
  logic [31:0] cycle_q, cycle_d;
  logic        irq_q,   irq_d;

  logic          mmio_sel_s;
  logic          reg_hit_s;
  logic          reg_wr_s;
  logic          match_s;
  logic [5:0]    off_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_s;
  logic          unused_s;

  assign mmio_sel_s = (bus.a[31:16] == MMIO_BASE);
  assign reg_hit_s  = mmio_sel_s && (bus.a[15:8] == 8'd0);
  assign reg_wr_s   = bus.we && reg_hit_s;
  assign off_s      = bus.a[7:2];
  assign idx_s      = bus.a[AW+1:2];
  assign match_s    = ctrl_q[0] && (count_q == cmp_q);
  assign unused_s   = &{1'b0, bus.a[1:0]};

  // Combinational load path: register window or RAM word.
  always_comb begin
    rd_s = 32'd0;
    if (reg_hit_s) begin
      case (off_s)
        OFF_LED:    rd_s = {24'd0, led_q};
        OFF_CTRL:   rd_s = {30'd0, ctrl_q};
        OFF_COUNT:  rd_s = count_q;
        OFF_CMP:    rd_s = cmp_q;
        OFF_STATUS: rd_s = {31'd0, flag_q};
        OFF_CYCLE:  rd_s = cycle_q;
        default:    rd_s = 32'd0;
      endcase
    end else if (mmio_sel_s) begin
      rd_s = 32'd0;
    end else begin
      rd_s = mem[idx_s];
    end
  end

  assign bus.rd = rd_s;

  // Next-state for peripheral registers; software COUNT write beats the tick, match beats W1C.
  always_comb begin
    led_d   = led_q;
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    cycle_d = cycle_q + 32'd1;

    if (reg_wr_s) begin
      case (off_s)
        OFF_LED:  led_d  = bus.wd[7:0];
        OFF_CTRL: ctrl_d = bus.wd[1:0];
        OFF_CMP:  cmp_d  = bus.wd;
        default:  led_d  = led_q;
      endcase
    end else begin
      led_d = led_q;
    end

    if (reg_wr_s && (off_s == OFF_COUNT)) begin
      count_d = bus.wd;
    end else if (match_s) begin
      count_d = 32'd0;
    end else if (ctrl_q[0]) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end

    if (match_s) begin
      flag_d = 1'b1;
    end else if (reg_wr_s && (off_s == OFF_STATUS) && bus.wd[0]) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end

    irq_d = flag_d & ctrl_d[1];
  end

  // Peripheral state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q   <= 8'd0;
      ctrl_q  <= 2'd0;
      count_q <= 32'd0;
      cmp_q   <= 32'd0;
      flag_q  <= 1'b0;
      cycle_q <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
      cycle_q <= cycle_d;
      irq_q   <= irq_d;
    end
  end

  // RAM store port; contents survive reset but a store is dropped while reset is low.
  always_ff @(posedge clk) begin
    if (reset && bus.we && !mmio_sel_s) begin
      mem[idx_s] <= bus.wd;
    end
  end

  assign led = led_q;
  assign irq = irq_q;

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory responder for the single-cycle MIPS core: serves the datapath's load/store port (address = ALU result, write data = rt register, read data back to the result mux).
- Contains a word-addressed RAM and a small memory-mapped peripheral window: LED register, programmable interval timer with sticky match flag and interrupt, and a free-running cycle counter.
- Reads are combinational so a load completes in the core's single cycle. Writes commit on the rising clock edge.

Parameters:
- DEPTH, 64, RAM size in 32-bit words; power of two, 4..4096.
- MMIO_BASE, 16'hFFFF, value of a[31:16] that selects the peripheral window.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  store strobe (memwrite from controller).
- a  input  32  byte address (datapath aluout).
- wd  input  32  store data (datapath writedata).
- rd  output  32  load data (datapath readdata), combinational.
- led  output  8  LED register contents.
- irq  output  1  timer interrupt request.

Behaviour:
- Decode:
  - a[31:16]==MMIO_BASE selects MMIO; otherwise RAM.
  - a[1:0] ignored (word access only).
  - RAM index = a[log2(DEPTH)+1:2]; higher bits alias.
- RAM:
  - rd = mem[index] combinationally.
  - When we=1, mem[index] <= wd at the edge.
  - A read of the same address in the write cycle returns the old value.
  - Contents are not reset.
- MMIO offsets (a[7:0]). Unlisted offsets read 0; writes to them are ignored. a[15:8] must be 0, else treat as unlisted.
  - 0x00 LED: RW, bits[7:0]; upper bits read 0.
  - 0x04 CTRL: RW. bit0 = timer enable, bit1 = irq enable; other bits read 0.
  - 0x08 COUNT: RW, 32-bit.
  - 0x0C CMP: RW, 32-bit.
  - 0x10 STATUS: bit0 = match flag. Write-1-to-clear; writing 0 has no effect.
  - 0x14 CYCLE: RO, 32-bit free-running counter; writes ignored.
- Timer, each edge with CTRL.bit0=1:
  - If COUNT==CMP: COUNT<=0 and flag<=1.
  - Else: COUNT<=COUNT+1.
  - Period is CMP+1 cycles.
  - CMP=0 sets the flag every enabled cycle.
  - COUNT wraps 0xFFFFFFFF->0 only if CMP is never reached.
- Simultaneous events:
  - Software write to COUNT beats the timer update that cycle.
  - Flag set by a match beats a W1C clear in the same cycle.
  - A write to CMP takes effect for the comparison from the next cycle.
- Enable handling: clearing enable freezes COUNT; the flag is held.
- irq = flag & CTRL.bit1, registered-state driven with no combinational path from a/we.
- CYCLE increments every edge regardless of enable and wraps at 2^32.
- Reset (asynchronous, reset=0):
  - LED, CTRL, COUNT, CMP, flag and CYCLE are cleared to 0; led=0, irq=0.
  - rd continues to reflect the decode of a (MMIO registers read 0; RAM undefined).
  - Reset asserted mid-operation aborts any pending write that edge.
  - Release takes effect on the first rising edge after reset=1.
- Latency: rd has 0 cycles from a. Register writes are visible on rd the cycle after we.

Test Plan:
- RAM store/load: sw 0xDEADBEEF to 0x0000_0010, then lw 0x10 -> rd=0xDEADBEEF. lw 0x10+4*DEPTH (alias) -> rd=0xDEADBEEF. Same-cycle read during write returns the prior value.
- LED/unmapped: write 0x1234_56A5 to 0xFFFF_0000 -> led=0xA5, read 0x0000_00A5. Write to 0xFFFF_0018 -> no register changes, read 0.
- Timer period: CMP=3, CTRL=0x3 -> COUNT sequence 0,1,2,3,0. Flag and irq rise on the edge where COUNT 3->0 and repeat every 4 cycles. CTRL=0x1 -> flag sets, irq stays 0.
- W1C collision: write STATUS=1 in the same cycle a match occurs -> flag remains 1. Write STATUS=1 the next cycle -> flag=0, irq=0. Writing STATUS=0 -> flag unchanged.
- COUNT write priority: with timer enabled, write COUNT=0x100 in a tick cycle -> next read 0x100, followed by 0x101.
- Async reset mid-run: after 50 cycles with timer enabled, pulse reset low between edges -> led, irq, COUNT, CYCLE=0 immediately. After release, CYCLE reads N after N edges.
